// File: rtl/serv_rf_access_if.sv
// serv_rf_access_if -- command/response bus between a client and serv_rf_access.
//   Command: i_cmd_valid/o_cmd_ready handshake, i_cmd_wr (0=read, 1=write),
//            i_cmd_rs1/i_cmd_rs2/i_cmd_rd register indices, i_cmd_wdata.
//   Response: o_rsp_valid/i_rsp_ready handshake, o_rsp_rdata0 (rs1), o_rsp_rdata1 (rs2).
//   With SERV_RF_ACCESS_DUAL_WRITE_EN defined, the command also carries
//   i_cmd_rd1, i_cmd_wen1 and i_cmd_wdata1 for the second write port.
// Signal names are given from the access block's point of view (i_ = into it).
interface serv_rf_access_if #(
  parameter int csr_regs = 4
);
  localparam int RW = $clog2(32 + csr_regs);

  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_wr;
  logic [RW-1:0] i_cmd_rs1;
  logic [RW-1:0] i_cmd_rs2;
  logic [RW-1:0] i_cmd_rd;
  logic [31:0]   i_cmd_wdata;
`ifdef SERV_RF_ACCESS_DUAL_WRITE_EN
  logic [RW-1:0] i_cmd_rd1;
  logic          i_cmd_wen1;
  logic [31:0]   i_cmd_wdata1;
`endif
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [31:0]   o_rsp_rdata0;
  logic [31:0]   o_rsp_rdata1;

  modport master (
    output i_cmd_valid, i_cmd_wr, i_cmd_rs1, i_cmd_rs2, i_cmd_rd, i_cmd_wdata,
`ifdef SERV_RF_ACCESS_DUAL_WRITE_EN
    output i_cmd_rd1, i_cmd_wen1, i_cmd_wdata1,
`endif
    output i_rsp_ready,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata0, o_rsp_rdata1
  );

  modport slave (
    input  i_cmd_valid, i_cmd_wr, i_cmd_rs1, i_cmd_rs2, i_cmd_rd, i_cmd_wdata,
`ifdef SERV_RF_ACCESS_DUAL_WRITE_EN
    input  i_cmd_rd1, i_cmd_wen1, i_cmd_wdata1,
`endif
    input  i_rsp_ready,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata0, o_rsp_rdata1
  );
endinterface

// File: rtl/serv_rf_access.sv
// serv_rf_access -- turns a parallel read/write command into a bit-serial
// register-file access (SERV style RF: request, wait for ready, 32-cycle
// LSB-first transfer) and returns a parallel response.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   bus (slave)           command/response handshake bus (serv_rf_access_if)
//   o_rreq / o_wreq       read / write request strobes to the RF
//   i_ready               RF ready, honoured only in REQ/WAIT
//   o_rreg0/1, o_wreg0/1  register indices
//   o_wen0/1, o_wdata0/1  serial write enables and data
//   i_rdata0/1            serial read data
//
// Optional feature: define SERV_RF_ACCESS_DUAL_WRITE_EN to enable the second
// write port (o_wreg1/o_wen1/o_wdata1 driven from the command); otherwise
// those outputs are constant 0.
module serv_rf_access #(
  parameter  int csr_regs = 4,
  localparam int RW       = $clog2(32 + csr_regs)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  serv_rf_access_if.slave bus,
  output logic          o_rreq,
  output logic          o_wreq,
  input  logic          i_ready,
  output logic [RW-1:0] o_rreg0,
  output logic [RW-1:0] o_rreg1,
  output logic [RW-1:0] o_wreg0,
  output logic [RW-1:0] o_wreg1,
  output logic          o_wen0,
  output logic          o_wen1,
  output logic          o_wdata0,
  output logic          o_wdata1,
  input  logic          i_rdata0,
  input  logic          i_rdata1
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_XFER, S_RSP
  } state_t;

  state_t        r_state, w_next;
  logic          w_accept;
  logic [4:0]    r_cnt;
  logic          r_wr;
  logic [RW-1:0] r_rs1, r_rs2, r_rd;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata0, r_rdata1;
`ifdef SERV_RF_ACCESS_DUAL_WRITE_EN
  logic [RW-1:0] r_rd1;
  logic          r_wen1;
  logic [31:0]   r_wdata1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_wr     <= 1'b0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
`ifdef SERV_RF_ACCESS_DUAL_WRITE_EN
      r_rd1    <= '0;
      r_wen1   <= 1'b0;
      r_wdata1 <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_wr     <= bus.i_cmd_wr;
        r_rs1    <= bus.i_cmd_rs1;
        r_rs2    <= bus.i_cmd_rs2;
        r_rd     <= bus.i_cmd_rd;
        r_wdata  <= bus.i_cmd_wdata;
        // Cleared here so a write response reads back as zero.
        r_rdata0 <= '0;
        r_rdata1 <= '0;
`ifdef SERV_RF_ACCESS_DUAL_WRITE_EN
        r_rd1    <= bus.i_cmd_rd1;
        r_wen1   <= bus.i_cmd_wen1;
        r_wdata1 <= bus.i_cmd_wdata1;
`endif
      end
      if (r_state == S_XFER) begin
        // 5-bit counter wraps 31 -> 0, leaving it ready for the next command.
        r_cnt <= r_cnt + 5'd1;
        if (!r_wr) begin
          r_rdata0[r_cnt] <= i_rdata0;
          r_rdata1[r_cnt] <= i_rdata1;
        end
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    w_accept        = 1'b0;
    bus.o_cmd_ready = 1'b0;
    o_rreq          = 1'b0;
    o_wreq          = 1'b0;
    o_wen0          = 1'b0;
    o_wdata0        = 1'b0;
    o_wen1          = 1'b0;
    o_wdata1        = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.o_cmd_ready = 1'b1;
        if (bus.i_cmd_valid) begin
          w_accept = 1'b1;
          w_next   = S_REQ;
        end
      end
      S_REQ: begin
        o_rreq = !r_wr;
        o_wreq = r_wr;
        w_next = i_ready ? S_XFER : S_WAIT;
      end
      S_WAIT: begin
        // Read request is a single pulse; write request is held until ready.
        o_wreq = r_wr;
        if (i_ready) w_next = S_XFER;
      end
      S_XFER: begin
        if (r_wr) begin
          // x0 is hardwired zero: run the transfer but never enable the write.
          o_wen0   = (r_rd != '0);
          o_wdata0 = r_wdata[r_cnt];
`ifdef SERV_RF_ACCESS_DUAL_WRITE_EN
          o_wen1   = r_wen1;
          o_wdata1 = r_wdata1[r_cnt];
`endif
        end
        if (r_cnt == 5'd31) w_next = S_RSP;
      end
      S_RSP: begin
        if (bus.i_rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.o_rsp_valid  = (r_state == S_RSP);
  assign bus.o_rsp_rdata0 = r_rdata0;
  assign bus.o_rsp_rdata1 = r_rdata1;
  assign o_rreg0          = r_rs1;
  assign o_rreg1          = r_rs2;
  assign o_wreg0          = r_rd;
`ifdef SERV_RF_ACCESS_DUAL_WRITE_EN
  assign o_wreg1          = r_rd1;
`else
  assign o_wreg1          = '0;
`endif

endmodule

// File: tb/tb_serv_rf_access.sv
// tb_serv_rf_access -- directed plus randomized bench for serv_rf_access.
// A bench-side register file serves serial reads and commits serial writes;
// an abstract array model (ref_rf) gives the expected read values.
module tb_serv_rf_access;
  localparam int CSR  = 4;
  localparam int RW   = $clog2(32 + CSR);
  localparam int NREG = 32 + CSR;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_ready, i_rdata0, i_rdata1;
  logic          o_rreq, o_wreq, o_wen0, o_wen1, o_wdata0, o_wdata1;
  logic [RW-1:0] o_rreg0, o_rreg1, o_wreg0, o_wreg1;

  serv_rf_access_if #(.csr_regs(CSR)) bus ();

  serv_rf_access #(.csr_regs(CSR)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .o_rreq(o_rreq), .o_wreq(o_wreq), .i_ready(i_ready),
    .o_rreg0(o_rreg0), .o_rreg1(o_rreg1), .o_wreg0(o_wreg0), .o_wreg1(o_wreg1),
    .o_wen0(o_wen0), .o_wen1(o_wen1), .o_wdata0(o_wdata0), .o_wdata1(o_wdata1),
    .i_rdata0(i_rdata0), .i_rdata1(i_rdata1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ref_rf [NREG];
  logic [31:0] rf_mem [NREG];
  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input bit wr, input logic [RW-1:0] rs1, rs2, rd, input logic [31:0] wd);
    bus.i_cmd_wr    = wr;
    bus.i_cmd_rs1   = rs1;
    bus.i_cmd_rs2   = rs2;
    bus.i_cmd_rd    = rd;
    bus.i_cmd_wdata = wd;
`ifdef SERV_RF_ACCESS_DUAL_WRITE_EN
    bus.i_cmd_rd1    = '0;
    bus.i_cmd_wen1   = 1'b0;
    bus.i_cmd_wdata1 = '0;
`endif
  endtask

  // One full transaction. d = cycles from REQ to i_ready, hold = cycles of
  // response back-pressure, abort_n = transfer bit at which reset hits (-1 none).
  task automatic txn(input bit wr, input logic [RW-1:0] rs1, rs2, rd, input logic [31:0] wdata,
                     input int d, input int hold, input int abort_n);
    int t0, wen_n, bad, side_bad;
    logic [31:0] a, b, cap, e0, e1, r0, r1;
    logic [RW-1:0] wreg;
    a = rf_mem[rs1];
    b = rf_mem[rs2];
    e0 = wr ? 32'h0 : ref_rf[rs1];
    e1 = wr ? 32'h0 : ref_rf[rs2];
    wreg = '0;

    chk("idle_ready", {31'h0, bus.o_cmd_ready}, 32'h1);
    bus.i_cmd_valid = 1'b1;
    drive_cmd(wr, rs1, rs2, rd, wdata);
    i_ready = 1'($urandom);          // must be ignored in IDLE
    t0 = cyc;
    step();
    bus.i_cmd_valid = 1'b0;
    drive_cmd(1'($urandom), RW'($urandom), RW'($urandom), RW'($urandom), $urandom);
    chk("req_strobes", {29'h0, bus.o_cmd_ready, o_rreq, o_wreq}, {29'h0, 1'b0, !wr, wr});

    for (int k = 0; k <= d; k++) begin
      i_ready = (k == d);
      if (k > 0) chk("wait_strobes", {30'h0, o_rreq, o_wreq}, {30'h0, 1'b0, wr});
      step();
    end
    i_ready = 1'b0;

    wen_n = 0; cap = '0; side_bad = 0;
    for (int n = 0; n < 32; n++) begin
      i_rdata0 = a[n];
      i_rdata1 = b[n];
      i_ready  = 1'($urandom);        // ignored during the transfer
      if (n == 0) begin
        chk("xfer_regs", {14'h0, o_rreg0, o_rreg1, o_wreg0}, {14'h0, rs1, rs2, rd});
        wreg = o_wreg0;
      end
      if (o_wen0) wen_n++;
      cap[n] = o_wdata0;
      if (bus.o_rsp_valid || bus.o_cmd_ready || o_rreq || (o_wreq && 1'b1)) side_bad++;
`ifndef SERV_RF_ACCESS_DUAL_WRITE_EN
      if (o_wen1 || o_wdata1 || o_wreg1 != '0) side_bad++;
`endif
      if (n == abort_n) rst = 1'b1;
      step();
      if (n == abort_n) begin
        rst = 1'b0;
        i_ready = 1'b0;
        chk("abort_idle", {30'h0, o_wen0, bus.o_cmd_ready}, 32'h1);
        bad = 0;
        for (int q = 0; q < 40; q++) begin
          if (bus.o_rsp_valid || o_wen0 || o_wreq || o_rreq) bad++;
          step();
        end
        chk("abort_quiet", bad, 0);
        return;
      end
    end
    i_ready = 1'b0; i_rdata0 = 1'b0; i_rdata1 = 1'b0;

    chk("xfer_side", side_bad, 0);
    chk("wen_cycles", wen_n, (wr && rd != '0) ? 32 : 0);
    if (wr && rd != '0) chk("wdata_serial", cap, wdata);
    chk("latency", cyc - t0, 34 + d);
    chk("rsp_valid", {31'h0, bus.o_rsp_valid}, 32'h1);
    chk("rdata0", bus.o_rsp_rdata0, e0);
    chk("rdata1", bus.o_rsp_rdata1, e1);

    r0 = bus.o_rsp_rdata0; r1 = bus.o_rsp_rdata1;
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      bus.i_cmd_valid = 1'b1;       // must not be accepted while responding
      if (!bus.o_rsp_valid || bus.o_cmd_ready || bus.o_rsp_rdata0 !== r0 ||
          bus.o_rsp_rdata1 !== r1 || o_wen0 || o_rreq || o_wreq) bad++;
      step();
    end
    bus.i_cmd_valid = 1'b0;
    if (hold > 0) chk("rsp_hold", bad, 0);

    bus.i_rsp_ready = 1'b1;
    step();
    bus.i_rsp_ready = 1'b0;
    chk("post_idle", {26'h0, bus.o_cmd_ready, bus.o_rsp_valid, o_rreq, o_wreq, o_wen0, o_wdata0},
        32'b100000);

    // Bench RF commits only a complete enabled write; model follows the ISA rule.
    if (wr && wen_n == 32) rf_mem[wreg] = cap;
    if (wr && rd != '0) ref_rf[rd] = wdata;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; i_ready = 1'b0; i_rdata0 = 1'b0; i_rdata1 = 1'b0;
    bus.i_cmd_valid = 1'b1;          // reset must win over a command
    bus.i_rsp_ready = 1'b0;
    drive_cmd(1'b1, 6'd1, 6'd2, 6'd3, 32'hA5A5A5A5);
    step(); step();
    rst = 1'b0;
    bus.i_cmd_valid = 1'b0;
    chk("reset_state", {27'h0, bus.o_cmd_ready, bus.o_rsp_valid, o_rreq, o_wreq, o_wen0},
        32'b10000);
    chk("reset_rdata", bus.o_rsp_rdata0 | bus.o_rsp_rdata1, 32'h0);
    step();
    chk("reset_stay_idle", {30'h0, o_rreq, o_wreq}, 32'h0);

    for (int i = 0; i < NREG; i++) begin
      ref_rf[i] = (i == 0) ? 32'h0 : $urandom;
      rf_mem[i] = ref_rf[i];
    end
    ref_rf[3] = 32'h12345678; rf_mem[3] = 32'h12345678;
    ref_rf[7] = 32'h80000001; rf_mem[7] = 32'h80000001;

    txn(1'b1, 6'd0, 6'd0, 6'd5, 32'hDEADBEEF, 0, 0, -1);   // write, ready in REQ
    txn(1'b0, 6'd3, 6'd7, 6'd0, 32'h0, 2, 0, -1);          // read, latency 36
    txn(1'b1, 6'd0, 6'd0, 6'd0, 32'hFFFFFFFF, 1, 0, -1);   // write to x0
    txn(1'b0, 6'd5, 6'd0, 6'd0, 32'h0, 1, 10, -1);         // back-pressure
    txn(1'b1, 6'd0, 6'd0, 6'd9, $urandom, 0, 0, 12);       // reset at bit 12
    txn(1'b0, 6'd9, 6'd5, 6'd0, 32'h0, 3, 2, -1);          // next command after abort

    for (int r = 0; r < 14; r++) begin
      txn(1'($urandom), RW'($urandom_range(0, NREG-1)), RW'($urandom_range(0, NREG-1)),
          RW'($urandom_range(0, NREG-1)), $urandom, $urandom_range(0, 3),
          $urandom_range(0, 3), -1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/serv_rf_access.md
SERV_RF_ACCESS -- requirements
Module: serv_rf_access

Interface
REQ-001 SHALL have parameter csr_regs, default 4, number of CSR registers above x0-x31; RW = $clog2(32+csr_regs), 6 by default.
REQ-002 SHALL have i_clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have i_rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have i_cmd_valid in 1 / o_cmd_ready out 1: command handshake, transfer when both high.
REQ-005 SHALL have i_cmd_wr in 1 (0=read, 1=write); i_cmd_rs1, i_cmd_rs2, i_cmd_rd in RW each; i_cmd_wdata in 32.
REQ-006 SHALL have o_rsp_valid out 1 / i_rsp_ready in 1; o_rsp_rdata0 out 32 (rs1 value); o_rsp_rdata1 out 32 (rs2 value).
REQ-007 SHALL have RF-side ports: o_rreq out 1, o_wreq out 1, i_ready in 1, o_rreg0/o_rreg1/o_wreg0/o_wreg1 out RW, o_wen0/o_wen1 out 1, o_wdata0/o_wdata1 out 1, i_rdata0/i_rdata1 in 1.

Function
REQ-008 SHALL implement FSM IDLE -> REQ -> WAIT -> XFER -> RSP -> IDLE.
REQ-009 o_cmd_ready SHALL be 1 only in IDLE; accepted command registered (op, regs, wdata) and FSM to REQ next cycle.
REQ-010 REQ (1 cycle): read drives o_rreq=1; write drives o_wreq=1; next state WAIT.
REQ-011 WAIT: write holds o_wreq=1 until i_ready sampled 1; read keeps o_rreq=0; i_ready=1 in REQ or WAIT moves to XFER next cycle.
REQ-012 i_ready before REQ (i.e. in IDLE/XFER/RSP) SHALL be ignored.
REQ-013 XFER SHALL last exactly 32 cycles, 5-bit counter n=0..31, bit n on serial lines in cycle n, LSB first.
REQ-014 Read XFER: sample i_rdata0 into o_rsp_rdata0[n], i_rdata1 into o_rsp_rdata1[n] each cycle.
REQ-015 Write XFER: o_wdata0 = wdata[n], o_wen0=1 all 32 cycles, except o_wen0=0 throughout when rd==0.
REQ-016 o_rreg0/o_rreg1 = latched rs1/rs2 and o_wreg0 = latched rd, stable from REQ through end of XFER.
REQ-017 After n=31: RSP; o_rsp_valid=1 held with data stable until i_rsp_ready=1, then IDLE next cycle.
REQ-018 Write responses SHALL return o_rsp_rdata0/1 = 0 (completion acknowledge only).
REQ-019 Outside REQ/WAIT/XFER all RF-side strobes (o_rreq, o_wreq, o_wen0, o_wen1) SHALL be 0; o_wdata0/1 = 0.
REQ-020 No back-to-back overlap: next command accepted earliest the cycle after the RSP handshake.
REQ-021 Read latency with i_ready 2 cycles after o_rreq: accept cycle 0, o_rreq cycle 1, i_ready cycle 3, XFER cycles 4-35, o_rsp_valid cycle 36.

Reset
REQ-022 i_rst SHALL force IDLE, counter 0, o_cmd_ready=1, o_rsp_valid=0, all RF strobes 0, rsp data 0, next cycle.
REQ-023 Reset mid-WAIT or mid-XFER SHALL abort with no response and no further o_wen pulses.
REQ-024 i_rst has priority over i_cmd_valid in the same cycle; that command is not accepted.

Configuration
REQ-025 Macro SERV_RF_ACCESS_DUAL_WRITE_EN SHALL control second write port.
REQ-026 Defined: extra inputs i_cmd_rd1 (RW), i_cmd_wen1 (1), i_cmd_wdata1 (32); write XFER drives o_wreg1=rd1, o_wdata1=wdata1[n], o_wen1=i_cmd_wen1 latched, same timing as port 0.
REQ-027 Not defined: those inputs absent, o_wreg1=0, o_wen1=0, o_wdata1=0 constant.

Verification
REQ-028 Reset then idle: o_cmd_ready=1, o_rsp_valid=0, o_rreq=o_wreq=o_wen0=0.
REQ-029 Write rd=5, wdata=0xDEADBEEF, i_ready 1 in REQ -> o_wen0=1 32 cycles, o_wdata0 sequence 1,1,1,1,0,1,1,1,... (LSB first), o_wreg0=5, rsp data 0.
REQ-030 Read rs1=3, rs2=7, model returns 0x12345678/0x80000001, i_ready 2 cycles after o_rreq -> o_rsp_valid cycle 36, rdata0=0x12345678, rdata1=0x80000001.
REQ-031 Write rd=0 wdata=0xFFFFFFFF -> o_wen0 never 1, response still returned.
REQ-032 i_rsp_ready low 10 cycles -> o_rsp_valid and data stable, o_cmd_ready=0, new i_cmd_valid not accepted.
REQ-033 i_rst at XFER n=12 of write -> o_wen0=0 next cycle, no o_rsp_valid, next command works normally.
